// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, plus the fetch-stage state encoding and reset PC.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  funct_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam word_t PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module fetch_next_pc
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  logic        branch_take,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] jaddr,
    input  logic        jr,
    input  word_t       jr_addr,
    output word_t       next_pc,
    output word_t       pc_plus4
);

    word_t branch_off_s;

    assign pc_plus4     = pc + 32'd4;
    assign branch_off_s = {{14{imm16[15]}}, imm16, 2'b00};

    // Priority mux; all additions wrap modulo 2^32
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_addr & 32'hFFFF_FFFC;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jaddr, 2'b00};
        end else if (branch_take) begin
            next_pc = pc_plus4 + branch_off_s;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instructions and holds the current
// word until the control unit lets it retire; freezes permanently on halt.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_RESET
)(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  word_t       imemload,
    output logic        imemREN,
    output word_t       imemaddr,
    input  logic        dstall,
    input  logic        halt,
    input  logic        branch_take,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] jaddr,
    input  logic        jr,
    input  word_t       jr_addr,
    output word_t       instr,
    output logic        instr_valid,
    output opcode_t     opcode,
    output funct_t      funct,
    output word_t       pc_plus4,
    output logic        halted
);

    fetch_state_t state_r, state_next_s;
    word_t        pc_r, pc_next_s, next_pc_s;
    word_t        instr_r, instr_next_s;
    logic         instr_valid_r, instr_valid_next_s;
    logic         halted_r, halted_next_s;

    fetch_next_pc u_next_pc (
        .pc          (pc_r),
        .branch_take (branch_take),
        .imm16       (imm16),
        .jump        (jump),
        .jaddr       (jaddr),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .next_pc     (next_pc_s),
        .pc_plus4    (pc_plus4)
    );

    // Next-state and datapath update; halt outranks dstall in EXEC
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        instr_next_s       = instr_r;
        instr_valid_next_s = instr_valid_r;
        halted_next_s      = halted_r;
        case (state_r)
            FETCH: begin
                if (ihit) begin
                    instr_next_s       = imemload;
                    instr_valid_next_s = 1'b1;
                    state_next_s       = EXEC;
                end else begin
                    state_next_s = FETCH;
                end
            end
            EXEC: begin
                if (halt) begin
                    halted_next_s = 1'b1;
                    state_next_s  = HALT;
                end else if (dstall) begin
                    state_next_s = EXEC;
                end else begin
                    pc_next_s          = next_pc_s;
                    instr_valid_next_s = 1'b0;
                    state_next_s       = FETCH;
                end
            end
            HALT: begin
                state_next_s = HALT;
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r       <= FETCH;
            pc_r          <= PC_INIT;
            instr_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            instr_r       <= instr_next_s;
            instr_valid_r <= instr_valid_next_s;
            halted_r      <= halted_next_s;
        end
    end

    assign imemREN     = (state_r == FETCH);
    assign imemaddr    = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign opcode      = instr_r[31:26];
    assign funct       = instr_r[5:0];
    assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    word_t       imemload;
    logic        imemREN;
    word_t       imemaddr;
    logic        dstall, halt, branch_take, jump, jr;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    word_t       jr_addr;
    word_t       instr;
    logic        instr_valid;
    opcode_t     opcode;
    funct_t      funct;
    word_t       pc_plus4;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model
    word_t m_pc;
    word_t m_instr;
    bit    m_have;
    bit    m_halted;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .dstall(dstall), .halt(halt),
        .branch_take(branch_take), .imm16(imm16), .jump(jump), .jaddr(jaddr),
        .jr(jr), .jr_addr(jr_addr), .instr(instr), .instr_valid(instr_valid),
        .opcode(opcode), .funct(funct), .pc_plus4(pc_plus4), .halted(halted)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imemREN"},     {31'd0, imemREN},     {31'd0, (!m_have && !m_halted)});
        chk({tag, ".imemaddr"},    imemaddr,             m_pc);
        chk({tag, ".pc_plus4"},    pc_plus4,             m_pc + 32'd4);
        chk({tag, ".instr"},       instr,                m_instr);
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, m_have});
        chk({tag, ".opcode"},      {26'd0, opcode},      {26'd0, m_instr[31:26]});
        chk({tag, ".funct"},       {26'd0, funct},       {26'd0, m_instr[5:0]});
        chk({tag, ".halted"},      {31'd0, halted},      {31'd0, m_halted});
    endtask

    function automatic word_t model_next_pc();
        word_t seq = m_pc + 32'd4;
        if (jr)          return {jr_addr[31:2], 2'b00};
        if (jump)        return (seq & 32'hF000_0000) | (word_t'(jaddr) * 32'd4);
        if (branch_take) return seq + word_t'($signed({{16{imm16[15]}}, imm16}) * 4);
        return seq;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_0000; m_instr = 32'h0; m_have = 0; m_halted = 0;
    endtask

    // one clock: model follows the rules at the edge, outputs checked at the negedge
    task automatic tick(input string tag);
        @(posedge CLK);
        if (m_halted) begin
        end else if (!m_have) begin
            if (ihit) begin m_instr = imemload; m_have = 1; end
        end else if (halt) begin
            m_halted = 1;
        end else if (!dstall) begin
            m_pc = model_next_pc();
            m_have = 0;
        end
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic clr();
        ihit = 0; imemload = 32'h0; dstall = 0; halt = 0; branch_take = 0;
        imm16 = 16'h0; jump = 0; jaddr = 26'h0; jr = 0; jr_addr = 32'h0;
    endtask

    task automatic do_reset(input string tag);
        #2 nRST = 1'b0;
        model_reset();
        #1 check_all({tag, ".in"});
        @(negedge CLK);
        nRST = 1'b1;
        #1 check_all({tag, ".rel"});
    endtask

    task automatic fetch_word(input word_t w);
        clr(); ihit = 1; imemload = w;
        tick("fetch");
        clr();
    endtask

    task automatic jr_to(input word_t a);
        clr(); jr = 1; jr_addr = a;
        tick("jr_to");
        clr();
    endtask

    initial begin
        clr();
        nRST = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset("reset");

        // 1: ihit on the second cycle after release
        tick("t1.wait");
        fetch_word(32'h2001_0005);
        chk("t1.opcode", {26'd0, opcode}, 32'h08);
        chk("t1.valid", {31'd0, instr_valid}, 32'd1);
        tick("t1.exec");
        chk("t1.addr4", imemaddr, 32'h0000_0004);

        // 2: branches from 0x40
        fetch_word(32'h0);
        jr_to(32'h0000_0040);
        fetch_word(32'h1000_FFFE);
        branch_take = 1; imm16 = 16'hFFFE;
        tick("t2.bneg"); clr();
        chk("t2.bneg.addr", imemaddr, 32'h0000_003C);
        fetch_word(32'h0);
        jr_to(32'h0000_0040);
        fetch_word(32'h1000_0003);
        branch_take = 1; imm16 = 16'h0003;
        tick("t2.bpos"); clr();
        chk("t2.bpos.addr", imemaddr, 32'h0000_0050);

        // 3: jump, then jr beating jump
        fetch_word(32'h0);
        jr_to(32'h1000_0010);
        fetch_word(32'h0800_0100);
        jump = 1; jaddr = 26'h000_0100;
        tick("t3.j"); clr();
        chk("t3.j.addr", imemaddr, 32'h1000_0400);
        fetch_word(32'h0);
        jump = 1; jaddr = 26'h3FF_FFFF; jr = 1; jr_addr = 32'h0000_0123;
        tick("t3.jr"); clr();
        chk("t3.jr.addr", imemaddr, 32'h0000_0120);

        // 4: dstall holds EXEC
        fetch_word(32'hABCD_1234);
        for (int i = 0; i < 3; i++) begin
            dstall = 1;
            tick("t4.stall");
            chk("t4.stall.ren", {31'd0, imemREN}, 32'd0);
            chk("t4.stall.addr", imemaddr, 32'h0000_0120);
        end
        clr();
        tick("t4.go");
        chk("t4.go.addr", imemaddr, 32'h0000_0124);

        // 5: halt beats dstall, then absorbing
        fetch_word(32'hFC00_0000);
        halt = 1; dstall = 1;
        tick("t5.halt"); clr();
        chk("t5.halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            ihit = i[0]; imemload = $urandom; jr = 1; jr_addr = $urandom;
            tick("t5.frozen");
            chk("t5.ren", {31'd0, imemREN}, 32'd0);
        end
        clr();
        do_reset("t5.reset");
        chk("t5.reset.addr", imemaddr, 32'h0000_0000);

        // 6: PC wrap, then reset mid-fetch
        fetch_word(32'h0);
        jr_to(32'hFFFF_FFFC);
        fetch_word(32'h0);
        tick("t6.wrap");
        chk("t6.wrap.addr", imemaddr, 32'h0000_0000);
        fetch_word(32'h0);
        jr_to(32'h0000_0800);
        tick("t6.fetchwait");
        do_reset("t6.reset");
        chk("t6.reset.valid", {31'd0, instr_valid}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ihit = ($urandom % 3) != 0;
            imemload = $urandom;
            dstall = ($urandom % 4) == 0;
            halt = ($urandom % 50) == 0;
            branch_take = $urandom % 2;
            imm16 = 16'($urandom);
            jump = ($urandom % 4) == 0;
            jaddr = 26'($urandom);
            jr = ($urandom % 6) == 0;
            jr_addr = $urandom;
            if (m_halted && ($urandom % 4) == 0) begin
                clr();
                do_reset("rnd.reset");
            end else begin
                tick("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
